// File: rtl/inpdt_accumulator.sv
// Streaming zero-point-corrected uint8 inner product with a saturating 32-bit accumulator.
// Latency: result valid the cycle after the last accepted beat (the cycle after start for an empty vector).
// Backpressure: in_ready only in ACCUM; the result is held in DONE until out_ready.
module inpdt_accumulator #(
  parameter logic [7:0] ZERO_DATA = 8'd128,
  parameter logic [7:0] ZERO_W    = 8'd128,
  parameter int         MAX_LEN   = 64,
  parameter int         LEN_W     = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        data_in,
  input  logic [7:0]        weight_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inpdt_R_reg,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   count_q;
  logic [31:0]        acc_q;

  logic signed [8:0]  data_c;
  logic signed [8:0]  weight_c;
  logic signed [17:0] prod;
  logic [32:0]        sum_wide;
  logic [31:0]        sum_sat;
  logic [LEN_W-1:0]   len_clamped;
  logic               beat;

  assign data_c   = $signed({1'b0, data_in})   - $signed({1'b0, ZERO_DATA});
  assign weight_c = $signed({1'b0, weight_in}) - $signed({1'b0, ZERO_W});
  assign prod     = data_c * weight_c;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign sum_wide = {acc_q[31], acc_q} + {{15{prod[17]}}, prod};

  always_comb begin
    sum_sat = sum_wide[31:0];
    if (sum_wide[32] != sum_wide[31])
      sum_sat = sum_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  assign len_clamped = (vec_len > MAX_LEN_C) ? MAX_LEN_C : vec_len;
  assign beat        = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      inpdt_R_reg <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q   <= len_clamped;
            count_q <= '0;
            acc_q   <= '0;
            busy    <= 1'b1;
            if (len_clamped == '0) begin
              inpdt_R_reg <= '0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q   <= sum_sat;
            count_q <= count_q + LEN_W'(1);
            if (count_q == len_q - LEN_W'(1)) begin
              inpdt_R_reg <= sum_sat;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
